sipo_rx: RTL and testbench

Serial-in, parallel-out UART receiver. It is the receive-side counterpart to the team's PISO transmitter and decodes the same 11-bit frame: start bit 0, eight data bits LSB first, one parity bit, stop bit 1. It oversamples `data_rx` on `baud_clk`, recovers the byte, checks parity and the stop bit, and presents the byte with a one-cycle `valid` strobe to the cold-storage control logic.

---
 rtl/sipo_rx_if.sv | 34 +++
 rtl/sipo_rx.sv | 169 ++++++++++++++++
 tb/tb_sipo_rx.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_rx_if.sv
// ============================================================================
// sipo_rx_if : serial line plus parallel result bus of the UART receiver
// Revision   : 1.0
// ============================================================================
`default_nettype none

interface sipo_rx_if;
   logic       data_rx;
   logic [7:0] data_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       active_flag;

   modport master (
      output data_rx,
      input  data_out,
      input  valid,
      input  parity_err,
      input  frame_err,
      input  active_flag
   );

   modport slave (
      input  data_rx,
      output data_out,
      output valid,
      output parity_err,
      output frame_err,
      output active_flag
   );
endinterface

`default_nettype wire

// File: rtl/sipo_rx.sv
// ============================================================================
// sipo_rx : oversampling UART receiver (start, 8 data LSB first, parity, stop)
// Option  : SIPO_RX_MAJORITY_EN selects 2-of-3 majority bit sampling
// Revision: 1.0
// ============================================================================
`default_nettype none

module sipo_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_ODD = 0
) (
   input  wire         baud_clk,
   input  wire         reset_n,
   sipo_rx_if.slave    bus
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam logic [TICK_W-1:0] c_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic              c_PAR_ODD   = (PARITY_ODD != 0);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;
   localparam logic [2:0] c_BREAK  = 3'd5;

   logic              r_sync1;
   logic              r_sync2;
   logic [2:0]        r_state;
   logic [2:0]        w_next_state;
   logic [TICK_W-1:0] r_tick;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift;
   logic              r_perr;
   logic [7:0]        r_data_out;
   logic              r_valid;
   logic              r_parity_err;
   logic              r_frame_err;
   logic              w_active;
   logic              w_bit;
   logic              w_mid;
   logic              w_last;

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= bus.data_rx;
         r_sync2 <= r_sync1;
      end
   end

`ifdef SIPO_RX_MAJORITY_EN
   // r_hist holds rx_s from one and two cycles before the sample tick
   logic [1:0] r_hist;

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hist <= 2'b11;
      end else begin
         r_hist <= {r_hist[0], r_sync2};
      end
   end

   assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
   assign w_bit = r_sync2;
`endif

   assign w_mid  = (r_tick == c_TICK_MID);
   assign w_last = (r_tick == c_TICK_LAST);

   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (!r_sync2) w_next_state = c_START;
         end
         c_START: begin
            if (w_mid) w_next_state = w_bit ? c_IDLE : c_DATA;
         end
         c_DATA: begin
            if (w_last && (r_bit_cnt == 3'd7)) w_next_state = c_PARITY;
         end
         c_PARITY: begin
            if (w_last) w_next_state = c_STOP;
         end
         c_STOP: begin
            if (w_last) w_next_state = w_bit ? c_IDLE : c_BREAK;
         end
         c_BREAK: begin
            if (r_sync2) w_next_state = c_IDLE;
         end
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      w_active = 1'b0;
      if (r_state != c_IDLE) w_active = 1'b1;
   end

   // Tick restarts at mid-start so every later sample lands on a bit centre
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick       <= '0;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'd0;
         r_perr       <= 1'b0;
         r_data_out   <= 8'd0;
         r_valid      <= 1'b0;
         r_parity_err <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if ((r_state == c_IDLE) || (r_state == c_BREAK)) begin
            r_tick <= '0;
         end else if (((r_state == c_START) && w_mid) || w_last) begin
            r_tick <= '0;
         end else begin
            r_tick <= r_tick + 1'b1;
         end

         case (r_state)
            c_START: begin
               if (w_mid) r_bit_cnt <= 3'd0;
            end
            c_DATA: begin
               if (w_last) begin
                  r_shift   <= {w_bit, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
               end
            end
            c_PARITY: begin
               if (w_last) r_perr <= (^r_shift) ^ w_bit ^ c_PAR_ODD;
            end
            c_STOP: begin
               if (w_last) begin
                  r_data_out   <= r_shift;
                  r_parity_err <= r_perr;
                  r_frame_err  <= ~w_bit;
                  r_valid      <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data_out    = r_data_out;
   assign bus.valid       = r_valid;
   assign bus.parity_err  = r_parity_err;
   assign bus.frame_err   = r_frame_err;
   assign bus.active_flag = w_active;

endmodule

`default_nettype wire

// File: tb/tb_sipo_rx.sv
// ============================================================================
// tb_sipo_rx : directed, table-driven bench for the sipo_rx UART receiver
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_sipo_rx;

   localparam int OS  = 16;
   localparam int LAT = 2 + OS / 2 + 10 * OS;
   localparam int FRAME_CYC = 11 * OS;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       exp_perr;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sipo_rx_if u_if ();

   sipo_rx #(
      .OVERSAMPLE (OS),
      .PARITY_ODD (0)
   ) u_dut (
      .baud_clk (clk),
      .reset_n  (rst_n),
      .bus      (u_if)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   int         vcount    = 0;
   int         vcyc      = 0;
   int         vcyc_prev = 0;
   logic [7:0] vdata      = 8'h00;
   logic [7:0] vdata_prev = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.valid) begin
         vcount     <= vcount + 1;
         vcyc_prev  <= vcyc;
         vcyc       <= cyc;
         vdata_prev <= vdata;
         vdata      <= u_if.data_out;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_lat(input string name);
      total++;
      if ((vcyc - t0 < LAT - 1) || (vcyc - t0 > LAT + 1)) begin
         bad++;
         $display("FAIL %s: latency got %0d expected %0d+-1", name, vcyc - t0, LAT);
      end
   endtask

   function automatic logic [10:0] mkframe(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   // Drives one line value per cycle; bit index i/OS, optional single-cycle inversion
   task automatic send(input logic [10:0] fr, input int ncyc, input int glitch);
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (i == 0) t0 = cyc + 1;
         u_if.data_rx = fr[i / OS] ^ (i == glitch);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      u_if.data_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   vec_t vecs [8];
   int   vc0;
   int   lows;

   initial begin
      vecs[0] = '{8'h41, 1'b0, 1'b0};
      vecs[1] = '{8'h41, 1'b1, 1'b1};
      vecs[2] = '{8'hA5, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 1'b0, 1'b1};
      vecs[5] = '{8'hFF, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 1'b0, 1'b0};
      vecs[7] = '{8'h7E, 1'b1, 1'b1};

      u_if.data_rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset data_out", int'(u_if.data_out), 0);
      chk("reset valid", int'(u_if.valid), 0);
      chk("reset parity_err", int'(u_if.parity_err), 0);
      chk("reset frame_err", int'(u_if.frame_err), 0);
      chk("reset active", int'(u_if.active_flag), 0);
      rst_n = 1'b1;
      idle(5);

      for (int k = 0; k < 8; k++) begin
         vc0 = vcount;
         send(mkframe(vecs[k].data, vecs[k].par, 1'b1), FRAME_CYC, -1);
         idle(20);
         chk($sformatf("vec%0d valid count", k), vcount - vc0, 1);
         chk($sformatf("vec%0d data", k), int'(u_if.data_out), int'(vecs[k].data));
         chk($sformatf("vec%0d parity_err", k), int'(u_if.parity_err), int'(vecs[k].exp_perr));
         chk($sformatf("vec%0d frame_err", k), int'(u_if.frame_err), 0);
         chk($sformatf("vec%0d active idle", k), int'(u_if.active_flag), 0);
         chk_lat($sformatf("vec%0d", k));
      end

      // Stop bit low, line held low afterwards
      vc0 = vcount;
      send(mkframe(8'h3C, 1'b0, 1'b0), FRAME_CYC, -1);
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (u_if.active_flag) lows++;
      end
      chk("break active held", lows, 40);
      chk("break valid count", vcount - vc0, 1);
      chk("break data", int'(u_if.data_out), 8'h3C);
      chk("break frame_err", int'(u_if.frame_err), 1);
      chk("break parity_err", int'(u_if.parity_err), 0);
      idle(10);
      chk("break active released", int'(u_if.active_flag), 0);
      chk("break no second valid", vcount - vc0, 1);

      // False start then a good frame
      vc0 = vcount;
      send(11'h7FE, 5, -1);
      idle(30);
      chk("false start no valid", vcount - vc0, 0);
      chk("false start active", int'(u_if.active_flag), 0);
      send(mkframe(8'hA5, 1'b0, 1'b1), FRAME_CYC, -1);
      idle(20);
      chk("after false start count", vcount - vc0, 1);
      chk("after false start data", int'(u_if.data_out), 8'hA5);
      chk("after false start perr", int'(u_if.parity_err), 0);

      // Back-to-back frames
      vc0 = vcount;
      send(mkframe(8'h55, 1'b0, 1'b1), FRAME_CYC, -1);
      send(mkframe(8'hAA, 1'b0, 1'b1), FRAME_CYC, -1);
      idle(20);
      chk("b2b count", vcount - vc0, 2);
      chk("b2b first data", int'(vdata_prev), 8'h55);
      chk("b2b second data", int'(vdata), 8'hAA);
      chk("b2b spacing", vcyc - vcyc_prev, FRAME_CYC);
      chk("b2b perr", int'(u_if.parity_err), 0);
      chk("b2b ferr", int'(u_if.frame_err), 0);

      // Reset during data bit 4
      vc0 = vcount;
      send(mkframe(8'h5A, 1'b0, 1'b1), OS + 4 * OS + OS / 2, -1);
      chk("abort active before reset", int'(u_if.active_flag), 1);
      @(negedge clk);
      rst_n = 1'b0;
      u_if.data_rx = 1'b1;
      @(negedge clk);
      chk("abort data_out", int'(u_if.data_out), 0);
      chk("abort valid", int'(u_if.valid), 0);
      chk("abort parity_err", int'(u_if.parity_err), 0);
      chk("abort frame_err", int'(u_if.frame_err), 0);
      chk("abort active", int'(u_if.active_flag), 0);
      rst_n = 1'b1;
      idle(200);
      chk("abort no valid", vcount - vc0, 0);
      chk("abort active after", int'(u_if.active_flag), 0);

      // One-cycle glitch at the centre of data bit 0 of 0x00
      vc0 = vcount;
      send(mkframe(8'h00, 1'b0, 1'b1), FRAME_CYC, OS + OS / 2);
      idle(20);
      chk("glitch count", vcount - vc0, 1);
`ifdef SIPO_RX_MAJORITY_EN
      chk("glitch data", int'(u_if.data_out), 8'h00);
      chk("glitch perr", int'(u_if.parity_err), 0);
`else
      chk("glitch data", int'(u_if.data_out), 8'h01);
      chk("glitch perr", int'(u_if.parity_err), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
